led_counter_ctrl: RTL and testbench
===================================

LED_COUNTER_CTRL -- requirements
Module: led_counter_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clkin cycles per count advance in RUN; legal range >= 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, stable cycles needed to accept a button level change; legal range >= 1.
REQ-003 clkin  input  1  single clock, 25 MHz; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 btn_run  input  1  asynchronous button, active-high; press toggles run/pause.
REQ-006 btn_step  input  1  asynchronous button; press advances the count by one when not running.
REQ-007 btn_dir  input  1  asynchronous button; press toggles the count direction.
REQ-008 btn_clear  input  1  asynchronous button; press returns to IDLE with count 0.
REQ-009 led  output  [0:3]  current count; led[0] is the MSB.
REQ-010 tick  output  1  one-cycle pulse on each timed advance in RUN.
REQ-011 state  output  2  IDLE=00, RUN=01, PAUSE=10; 11 is never driven.
REQ-012 dir_up  output  1  1 = count up, 0 = count down.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then an optional debouncer (REQ-030/031), then a registered rising-edge detector that produces a 1-cycle event.
REQ-014 Without debounce, a button rising before edge E0 SHALL produce a visible state/led/dir_up change after edge E3.
REQ-015 The FSM SHALL have three states, IDLE, RUN and PAUSE, with these transitions:
- IDLE: run goes to RUN; step goes to PAUSE.
- RUN: run goes to PAUSE.
- PAUSE: run goes to RUN.
- Any state: clear goes to IDLE.
REQ-016 The step event SHALL change the count by 1 in IDLE and PAUSE, and SHALL be ignored in RUN.
REQ-017 The prescaler divider SHALL run only in RUN, SHALL be 0 on entry to RUN, and SHALL count 0..TICK_DIV-1.
REQ-018 tick SHALL pulse, and the count SHALL advance, when the divider equals TICK_DIV-1; the first advance SHALL occur TICK_DIV cycles after RUN entry.
REQ-019 The divider value SHALL be held in PAUSE and zeroed in IDLE; RUN re-entry from PAUSE SHALL restart it at 0.
REQ-020 The count is 4 bits and SHALL wrap: up from 15 goes to 0; down from 0 goes to 15.
REQ-021 The dir event SHALL toggle dir_up in every state.
REQ-022 Simultaneous events SHALL resolve by priority clear > run > step.
REQ-023 Because of REQ-022:
- clear together with anything SHALL give IDLE, count 0 and no tick, with dir still toggled if dir was present;
- run together with a tick in RUN SHALL give PAUSE with no advance and no tick.
REQ-024 A step and a dir event in the same cycle SHALL use the direction in effect before the toggle.
REQ-025 A button held down SHALL produce exactly one event; only a new release followed by a press generates another.
REQ-026 led, state and dir_up SHALL be registered outputs, with no combinational path from any button input.

Reset
REQ-027 rst_n low SHALL asynchronously set the outputs and internal state as follows:
- state=IDLE, led=0000, tick=0, dir_up=1, divider=0;
- synchronizer, debounce and edge-detect registers = 0.
REQ-028 Deassertion of rst_n SHALL be synchronous to clkin, with first legal activity at the second edge after deassertion.
REQ-029 Reset asserted mid-RUN SHALL discard all pending events and divider progress.

Configuration
REQ-030 Macro LED_COUNTER_CTRL_DEBOUNCE_EN defined: the debounced level SHALL change only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; a differing run shorter than that SHALL reset the debounce counter. Latency becomes 3+DEBOUNCE_CYCLES cycles.
REQ-031 Macro LED_COUNTER_CTRL_DEBOUNCE_EN undefined: no debounce logic or counters SHALL be built, the synchronizer output SHALL feed the edge detect directly, and the DEBOUNCE_CYCLES parameter SHALL be accepted but unused.

Verification
REQ-032 The bench SHALL use TICK_DIV=4 and DEBOUNCE_CYCLES=3 and cover the following scenarios:
- Reset, then press run: state=01 at E3; tick every 4 cycles; led 0,1,2,...,15,0 (wrap checked).
- While in RUN, press run in the cycle of a tick: state=10, no tick, led unchanged; press run again: next advance 4 cycles after RUN entry.
- From IDLE, press dir then step x2: dir_up=0, state=10, led 15 then 14.
- Press clear together with step in PAUSE at led=9: state=00, led=0, no change from step.
- With the macro defined, a btn_run glitch of 2 cycles: no event; held for 5 cycles: one event, state change at E6; button held for 100 cycles: single event.
- Assert rst_n low mid-RUN at led=7: immediate led=0, state=00, tick=0, dir_up=1.

Source files
------------

// File: rtl/led_counter_ctrl.sv
// led_counter_ctrl: four-button controller for a 4-bit LED counter.
// Buttons pass through a 2-flop synchronizer, an optional debouncer and a
// registered rising-edge detector before driving the IDLE/RUN/PAUSE FSM.
// Define LED_COUNTER_CTRL_DEBOUNCE_EN to build the debouncer; without it the
// synchronizer feeds the edge detector directly and DEBOUNCE_CYCLES is unused.
module led_counter_ctrl #(
    parameter int TICK_DIV        = 25000000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_dir,
    input  logic       btn_clear,
    output logic [0:3] led,
    output logic       tick,
    output logic [1:0] state,
    output logic       dir_up
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    // Count one position in the chosen direction; 4-bit arithmetic wraps 15<->0.
    function automatic logic [3:0] step_count(input logic [3:0] cur, input logic up);
        return up ? (cur + 4'd1) : (cur - 4'd1);
    endfunction

    logic rst_sync_p0;
    logic rst_sync_p1;
    logic rst_int_n;

    // Internal reset asserts immediately with rst_n and releases on the second clock edge.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_p0 <= 1'b0;
            rst_sync_p1 <= 1'b0;
        end else begin
            rst_sync_p0 <= 1'b1;
            rst_sync_p1 <= rst_sync_p0;
        end
    end

    assign rst_int_n = rst_sync_p1;

    // Bit order throughout the button path: {clear, dir, step, run}.
    logic [3:0] btn_raw;
    logic [3:0] sync_p0;
    logic [3:0] sync_p1;
    logic [3:0] level;

    assign btn_raw = {btn_clear, btn_dir, btn_step, btn_run};

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clkin or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debounce stage ----
`ifdef LED_COUNTER_CTRL_DEBOUNCE_EN
    localparam int               DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [DEB_W-1:0] deb_cnt [4];

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clkin or negedge rst_int_n) begin
        if (!rst_int_n) begin
            level <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    level[i]   <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end
`else
    assign level = sync_p1;
`endif

    // ---- edge-detect stage ----
    logic [3:0] level_prev;
    logic [3:0] evt;
    logic       ev_run;
    logic       ev_step;
    logic       ev_dir;
    logic       ev_clear;

    // Registered rising-edge detector: a held button yields a single one-cycle event.
    always_ff @(posedge clkin or negedge rst_int_n) begin
        if (!rst_int_n) begin
            level_prev <= '0;
            evt        <= '0;
        end else begin
            level_prev <= level;
            evt        <= level & ~level_prev;
        end
    end

    assign ev_run   = evt[0];
    assign ev_step  = evt[1];
    assign ev_dir   = evt[2];
    assign ev_clear = evt[3];

    // ---- FSM / counter stage ----
    logic [3:0]       count;
    logic [DIV_W-1:0] div;

    // Mode FSM, prescaler and counter; clear beats run, run beats step and tick.
    always_ff @(posedge clkin or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state  <= ST_IDLE;
            count  <= '0;
            div    <= '0;
            tick   <= 1'b0;
            dir_up <= 1'b1;
        end else begin
            tick <= 1'b0;
            if (ev_dir) begin
                dir_up <= ~dir_up;
            end
            if (ev_clear) begin
                state <= ST_IDLE;
                count <= '0;
                div   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        div <= '0;
                        if (ev_run) begin
                            state <= ST_RUN;
                        end else if (ev_step) begin
                            state <= ST_PAUSE;
                            count <= step_count(count, dir_up);
                        end
                    end
                    ST_RUN: begin
                        if (ev_run) begin
                            state <= ST_PAUSE;
                        end else if (div == DIV_LAST) begin
                            div   <= '0;
                            tick  <= 1'b1;
                            count <= step_count(count, dir_up);
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (ev_run) begin
                            state <= ST_RUN;
                            div   <= '0;
                        end else if (ev_step) begin
                            count <= step_count(count, dir_up);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        div   <= '0;
                    end
                endcase
            end
        end
    end

    assign led = count;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Testbench for led_counter_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// A behavioural model predicts the outputs every cycle; directed literal
// checks pin key moments. The debounce scenarios build only when
// LED_COUNTER_CTRL_DEBOUNCE_EN is defined.
module tb_led_counter_ctrl;

    localparam int TICK_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 3;

`ifdef LED_COUNTER_CTRL_DEBOUNCE_EN
    localparam int LAT     = 3 + DEBOUNCE_CYCLES;  // press-start to state-change edge
    localparam int HOLD    = DEBOUNCE_CYCLES + 1;  // press length used by press()
    localparam int FILT_N  = DEBOUNCE_CYCLES;      // samples needed to accept a level
    localparam int ACT_DLY = 4;                    // accepted-level to action edge
`else
    localparam int LAT     = 3;
    localparam int HOLD    = 2;
    localparam int FILT_N  = 1;
    localparam int ACT_DLY = 3;
`endif

    localparam logic [3:0] B_RUN  = 4'b0001;
    localparam logic [3:0] B_STEP = 4'b0010;
    localparam logic [3:0] B_DIR  = 4'b0100;
    localparam logic [3:0] B_CLR  = 4'b1000;

    logic       clkin;
    logic       rst_n;
    logic       btn_run;
    logic       btn_step;
    logic       btn_dir;
    logic       btn_clear;
    logic [0:3] led;
    logic       tick;
    logic [1:0] state;
    logic       dir_up;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 0;

    led_counter_ctrl #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .btn_dir  (btn_dir),
        .btn_clear(btn_clear),
        .led      (led),
        .tick     (tick),
        .state    (state),
        .dir_up   (dir_up)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, required finish before 100000");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    int         m_state;    // 0 IDLE, 1 RUN, 2 PAUSE
    int         m_cnt;
    bit         m_dir;
    bit         m_tick;
    int         m_run_cyc;  // clock edges spent in RUN since entry
    bit   [3:0] f_lvl;      // accepted button levels
    int         f_run [4];  // consecutive samples differing from f_lvl
    logic [3:0] evq [$];    // accepted rising edges awaiting their action edge

    task automatic model_reset();
        m_state   = 0;
        m_cnt     = 0;
        m_dir     = 1'b1;
        m_tick    = 1'b0;
        m_run_cyc = 0;
        f_lvl     = '0;
        for (int b = 0; b < 4; b++) f_run[b] = 0;
        evq.delete();
        for (int i = 0; i < ACT_DLY; i++) evq.push_back(4'b0000);
    endtask

    task automatic model_step();
        logic [3:0] raw;
        logic [3:0] rose;
        logic [3:0] ev;
        bit         old_dir;
        raw  = {btn_clear, btn_dir, btn_step, btn_run};
        rose = '0;
        for (int b = 0; b < 4; b++) begin
            if (raw[b] != f_lvl[b]) begin
                f_run[b]++;
                if (f_run[b] == FILT_N) begin
                    f_lvl[b] = raw[b];
                    f_run[b] = 0;
                    rose[b]  = raw[b];
                end
            end else begin
                f_run[b] = 0;
            end
        end
        ev = evq.pop_front();
        evq.push_back(rose);

        old_dir = m_dir;
        if (ev[2]) m_dir = ~m_dir;
        m_tick = 1'b0;
        if (ev[3]) begin
            m_state = 0;
            m_cnt   = 0;
        end else if (m_state == 1) begin
            if (ev[0]) begin
                m_state = 2;
            end else begin
                m_run_cyc++;
                if (m_run_cyc % TICK_DIV == 0) begin
                    m_tick = 1'b1;
                    m_cnt  = (m_cnt + (old_dir ? 1 : 15)) % 16;
                end
            end
        end else begin
            if (ev[0]) begin
                m_state   = 1;
                m_run_cyc = 0;
            end else if (ev[1]) begin
                m_state = 2;
                m_cnt   = (m_cnt + (old_dir ? 1 : 15)) % 16;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clkin or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [7:0] got;
        logic [7:0] exp;
        forever begin
            @(negedge clkin);
            if (cmp_en) begin
                got = {state, led, tick, dir_up};
                exp = {2'(m_state), 4'(m_cnt), m_tick, m_dir};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL model_cycle t=%0t: got state=%b led=%0d tick=%b dir_up=%b, required state=%b led=%0d tick=%b dir_up=%b",
                             $time, got[7:6], got[5:2], got[1], got[0], exp[7:6], exp[5:2], exp[1], exp[0]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %0d, required %0d", name, $time, got, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] m);
        btn_run   = m[0];
        btn_step  = m[1];
        btn_dir   = m[2];
        btn_clear = m[3];
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    // Press, release, and return at the negedge just before the action edge.
    task automatic press(input logic [3:0] m);
        set_btns(m);
        cyc(HOLD);
        set_btns(4'b0000);
        cyc(LAT - HOLD);
    endtask

    initial begin
        bit found;
        set_btns(4'b0000);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        cyc(3);
        chk("reset_state",  8'(state),  8'd0);
        chk("reset_led",    8'(led),    8'd0);
        chk("reset_tick",   8'(tick),   8'd0);
        chk("reset_dir_up", 8'(dir_up), 8'd1);
        rst_n = 1'b1;
        cyc(5);

        // Run from IDLE, tick cadence and wrap 15 -> 0.
        press(B_RUN);
        chk("run_pre_state", 8'(state), 8'd0);
        cyc(1);
        chk("run_entry_state", 8'(state), 8'd1);
        chk("run_entry_led",   8'(led),   8'd0);
        cyc(3);
        chk("first_tick_pre", 8'(tick), 8'd0);
        cyc(1);
        chk("first_tick",     8'(tick), 8'd1);
        chk("first_adv_led",  8'(led),  8'd1);
        cyc(1);
        chk("tick_one_cycle", 8'(tick), 8'd0);
        cyc(55);
        chk("led_15", 8'(led), 8'd15);
        cyc(4);
        chk("wrap_led_0",  8'(led),  8'd0);
        chk("wrap_tick",   8'(tick), 8'd1);

        // Run pressed on a tick edge: pause wins, no advance.
        cyc(7 - LAT);
        press(B_RUN);
        chk("runtick_pre_led", 8'(led), 8'd1);
        cyc(1);
        chk("runtick_state", 8'(state), 8'd2);
        chk("runtick_tick",  8'(tick),  8'd0);
        chk("runtick_led",   8'(led),   8'd1);
        press(B_RUN);
        cyc(1);
        chk("rerun_state", 8'(state), 8'd1);
        cyc(3);
        chk("rerun_no_tick", 8'(tick), 8'd0);
        chk("rerun_led_hold", 8'(led), 8'd1);
        cyc(1);
        chk("rerun_tick", 8'(tick), 8'd1);
        chk("rerun_led",  8'(led),  8'd2);

        // Clear back to IDLE, then dir and two steps downward.
        press(B_CLR);
        cyc(1);
        chk("clear_state", 8'(state), 8'd0);
        chk("clear_led",   8'(led),   8'd0);
        chk("clear_tick",  8'(tick),  8'd0);
        press(B_DIR);
        cyc(1);
        chk("dir_toggle", 8'(dir_up), 8'd0);
        press(B_STEP);
        cyc(1);
        chk("step1_state", 8'(state), 8'd2);
        chk("step1_led",   8'(led),   8'd15);
        press(B_STEP);
        cyc(1);
        chk("step2_led", 8'(led), 8'd14);
        for (int i = 0; i < 5; i++) begin
            press(B_STEP);
            cyc(1);
        end
        chk("pause_led_9", 8'(led), 8'd9);

        // Clear with step and dir in PAUSE.
        press(B_CLR | B_STEP | B_DIR);
        cyc(1);
        chk("clrstep_state", 8'(state),  8'd0);
        chk("clrstep_led",   8'(led),    8'd0);
        chk("clrstep_dir",   8'(dir_up), 8'd1);

        // Step with dir in the same cycle uses the old direction (up).
        press(B_STEP | B_DIR);
        cyc(1);
        chk("stepdir_led",   8'(led),    8'd1);
        chk("stepdir_dir",   8'(dir_up), 8'd0);
        chk("stepdir_state", 8'(state),  8'd2);

        // Held run gives exactly one event; step in RUN is ignored.
        set_btns(B_RUN);
        cyc(20);
        chk("held_run_state", 8'(state), 8'd1);
        set_btns(4'b0000);
        cyc(4);
        press(B_STEP);
        cyc(1);
        chk("step_in_run_state", 8'(state), 8'd1);

        // Reset mid-RUN at led=7.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clkin);
            if (led == 4'd7 && state == 2'b01) found = 1'b1;
        end
        chk("reach_led_7", 8'(found), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_led",    8'(led),    8'd0);
        chk("midrst_state",  8'(state),  8'd0);
        chk("midrst_tick",   8'(tick),   8'd0);
        chk("midrst_dir_up", 8'(dir_up), 8'd1);
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        chk("post_reset_state", 8'(state), 8'd0);

`ifdef LED_COUNTER_CTRL_DEBOUNCE_EN
        // 2-cycle glitch is rejected.
        set_btns(B_RUN);
        cyc(2);
        set_btns(4'b0000);
        cyc(10);
        chk("glitch_state", 8'(state), 8'd0);
        // 5-cycle press is accepted with the state change on E6.
        set_btns(B_RUN);
        cyc(5);
        set_btns(4'b0000);
        cyc(1);
        chk("deb5_pre_state", 8'(state), 8'd0);
        cyc(1);
        chk("deb5_state", 8'(state), 8'd1);
        cyc(8);
        // 100-cycle hold is a single event.
        set_btns(B_RUN);
        cyc(100);
        chk("deb_hold_state", 8'(state), 8'd2);
        set_btns(4'b0000);
        cyc(10);
        chk("deb_release_state", 8'(state), 8'd2);
`endif

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
